// File: rtl/sw_input_ctrl.sv
// Switch front end: synchronises SW_raw, debounces the handshake bit and freezes the data word while it is high.
// Optional SW_HS_COUNT_EN: drives hs_count from a live capture counter; otherwise hs_count is tied to zero.
module sw_input_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int n         = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n:0]   SW_raw,
  output logic [n:0]   SW,
  output logic         new_data,
  output logic [1:0]   state,
  output logic [7:0]   hs_count
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HELD    = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

  logic [n:0]    sync1_q, sync2_q;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          stable_q, stable_d;
  state_t        state_q, state_d;
  logic [n:0]    sw_q, sw_d;
  logic          new_data_q, new_data_d;
  logic          capture;

  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (sync2_q[n] != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q[n];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Data and handshake are loaded on the same edge so SW[n]=1 never shows stale data.
  always_comb begin
    state_d    = state_q;
    sw_d       = sw_q;
    new_data_d = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sw_d[n] = 1'b0;
        if (stable_q) begin
          state_d    = ST_CAPTURE;
          sw_d       = {1'b1, sync2_q[n-1:0]};
          new_data_d = 1'b1;
          capture    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!stable_q) begin
          state_d = ST_IDLE;
          sw_d[n] = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sw_d[n] = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_cnt_q   <= '0;
      stable_q   <= 1'b0;
      state_q    <= ST_IDLE;
      sw_q       <= '0;
      new_data_q <= 1'b0;
    end else begin
      sync1_q    <= SW_raw;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      sw_q       <= sw_d;
      new_data_q <= new_data_d;
    end
  end

`ifdef SW_HS_COUNT_EN
  logic [7:0] hs_cnt_q, hs_cnt_d;

  always_comb begin
    hs_cnt_d = hs_cnt_q;
    if (capture) hs_cnt_d = hs_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) hs_cnt_q <= 8'd0;
    else       hs_cnt_q <= hs_cnt_d;
  end

  assign hs_count = hs_cnt_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign hs_count       = 8'h00;
`endif

  assign SW       = sw_q;
  assign new_data = new_data_q;
  assign state    = state_q;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Directed bench for sw_input_ctrl with DB_CYCLES=4 (capture 7 edges after a clean handshake rise).
module tb_sw_input_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] SW_raw;
  logic [8:0] SW;
  logic       new_data;
  logic [1:0] state;
  logic [7:0] hs_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_caps   = 0;

  sw_input_ctrl #(.DB_CYCLES(4), .n(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .SW_raw   (SW_raw),
    .SW       (SW),
    .new_data (new_data),
    .state    (state),
    .hs_count (hs_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_hs(input int caps);
`ifdef SW_HS_COUNT_EN
    return 8'(caps);
`else
    return 8'h00 + 8'(caps * 0);
`endif
  endfunction

  task automatic press_release(input logic [7:0] data);
    SW_raw = {1'b1, data};
    tick(7);
    n_caps++;
    SW_raw = {1'b0, data};
    tick(8);
  endtask

  initial begin
    int pulses;
    reset  = 1'b1;
    SW_raw = 9'h1FF;
    tick(2);
    check("rst_sw", SW, 9'h000);
    check("rst_nd", new_data, 1'b0);
    check("rst_state", state, 2'd0);
    check("rst_hs", hs_count, 8'h00);
    reset  = 1'b0;
    SW_raw = 9'h000;
    tick(3);

    // Bounce: three cycles of handshake is one short of acceptance.
    SW_raw = 9'h15A;
    tick(3);
    SW_raw = 9'h05A;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (new_data) pulses++;
    end
    check("bounce_pulse", pulses, 0);
    check("bounce_sw", SW, 9'h000);
    check("bounce_state", state, 2'd0);

    // Clean press.
    SW_raw = 9'h1A5;
    tick(6);
    check("press_sw_early", SW, 9'h000);
    check("press_state_idle", state, 2'd0);
    tick(1);
    n_caps++;
    check("press_sw", SW, 9'h1A5);
    check("press_nd", new_data, 1'b1);
    check("press_state_cap", state, 2'd1);
    check("press_hs", hs_count, exp_hs(n_caps));
    tick(1);
    check("press_nd_low", new_data, 1'b0);
    check("press_state_held", state, 2'd2);

    // Data changes while held are ignored.
    SW_raw = 9'h13C;
    tick(6);
    check("freeze_sw", SW, 9'h1A5);
    check("freeze_state", state, 2'd2);

    // Release.
    SW_raw = 9'h03C;
    tick(5);
    check("rel_sw_early", SW, 9'h1A5);
    tick(2);
    check("rel_sw", SW, 9'h0A5);
    check("rel_state", state, 2'd0);
    tick(2);

    // Second press with new data.
    SW_raw = 9'h13C;
    tick(7);
    n_caps++;
    check("press2_sw", SW, 9'h13C);
    check("press2_nd", new_data, 1'b1);
    check("press2_hs", hs_count, exp_hs(n_caps));
    SW_raw = 9'h03C;
    tick(8);
    check("rel2_sw", SW, 9'h03C);

    // Drive the capture counter to 255 and across the wrap.
    while (n_caps < 255) press_release(8'(n_caps));
    check("hs_255", hs_count, exp_hs(255));
    check("hs_255_sw", SW, {1'b0, 8'd254});
    press_release(8'h77);
    check("hs_wrap", hs_count, exp_hs(0));
    check("hs_wrap_sw", SW, 9'h077);

    // Reset while held, handshake still high.
    SW_raw = 9'h1C3;
    tick(8);
    check("mid_state_held", state, 2'd2);
    check("mid_sw_held", SW, 9'h1C3);
    reset = 1'b1;
    tick(1);
    check("mid_rst_sw", SW, 9'h000);
    check("mid_rst_state", state, 2'd0);
    check("mid_rst_hs", hs_count, 8'h00);
    reset = 1'b0;
    tick(6);
    check("mid_sw_early", SW, 9'h000);
    check("mid_nd_early", new_data, 1'b0);
    tick(1);
    check("mid_recap_sw", SW, 9'h1C3);
    check("mid_recap_nd", new_data, 1'b1);
    check("mid_recap_hs", hs_count, exp_hs(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
